// File: rtl/arb_pkg.sv
// Shared encodings for the CPU/DMA memory-port arbiter: FSM state values
// and the owner select that steers the memory-port mux.
package arb_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] HOLD_REQ = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = RUN,
    ST_HOLD_REQ = HOLD_REQ,
    ST_HOLD     = HOLD
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  function automatic logic cpu_active(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single memory port shared by the CPU (fixed priority) and a DMA requester,
// with a starvation-forced CPU hold window. Optional ARB_ERR_EN adds err_hold_access.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW           = 13,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int MAX_BURST    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_hold,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_ERR_EN
  ,
  output logic          err_hold_access
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 2);
  localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

  state_t        state;
  owner_t        owner;
  logic          cpu_act;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic [DW-1:0] rdata_hold;

  // Owner select: CPU wins in RUN, passes through the quiesce cycle, is locked out in HOLD.
  always_comb begin
    cpu_act = cpu_active(cpu_rd, cpu_wr);
    owner   = OWN_NONE;
    case (state)
      ST_RUN: begin
        if (cpu_act) begin
          owner = OWN_CPU;
        end else if (dma_req) begin
          owner = OWN_DMA;
        end else begin
          owner = OWN_NONE;
        end
      end
      ST_HOLD_REQ: begin
        if (cpu_act) begin
          owner = OWN_CPU;
        end else begin
          owner = OWN_NONE;
        end
      end
      ST_HOLD: begin
        if (dma_req) begin
          owner = OWN_DMA;
        end else begin
          owner = OWN_NONE;
        end
      end
      default: owner = OWN_NONE;
    endcase
  end

  // Memory-port mux; a simultaneous CPU read and write resolves to the write.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_CPU: begin
        mem_wr    = cpu_wr;
        mem_rd    = cpu_rd & ~cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        mem_wr    = dma_we;
        mem_rd    = ~dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  assign dma_ack = (owner == OWN_DMA);

  // Arbitration FSM with starvation and burst counters; cpu_hold is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cpu_hold   <= 1'b0;
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (dma_req && !dma_ack) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == STARVE_LAST) begin
              state    <= ST_HOLD_REQ;
              cpu_hold <= 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        ST_HOLD_REQ: state <= ST_HOLD;
        ST_HOLD: begin
          if (dma_req && (beat_cnt != BURST_LAST)) begin
            beat_cnt <= beat_cnt + 1'b1;
          end else begin
            state      <= ST_RUN;
            cpu_hold   <= 1'b0;
            starve_cnt <= '0;
            beat_cnt   <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking; the memory's own output register supplies the data in the
  // rvalid cycle, and the local copy keeps dma_rdata stable afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_rvalid <= 1'b0;
      rdata_hold <= '0;
    end else begin
      dma_rvalid <= dma_ack & ~dma_we;
      if (dma_rvalid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  assign dma_rdata = dma_rvalid ? mem_rdata : rdata_hold;

`ifdef ARB_ERR_EN
  // Sticky flag for CPU strobes that arrive while the CPU is locked out.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_hold_access <= 1'b0;
    end else if ((state == ST_HOLD) && cpu_act) begin
      err_hold_access <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int SL = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_hold;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_ERR_EN
  logic          err_hold_access;
`endif

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:15];
  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_ERR_EN
    , .err_hold_access(err_hold_access)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Returns the number of cycles before cpu_hold was seen (at a negedge), or -1.
  task automatic wait_hold(output int n, output int acks);
    n = -1;
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_hold === 1'b1) begin
        n = i;
        break;
      end
      if (dma_ack === 1'b1) acks++;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({cpu_hold, dma_ack, dma_rvalid, dma_rdata, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got hold=%b ack=%b rv=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h, want all 0",
               cpu_hold, dma_ack, dma_rvalid, dma_rdata, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    step();
  endtask

  task automatic test_dma_write_read();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h010; dma_wdata = 8'h05;
    @(negedge clk);
    n_checks++;
    if ({dma_ack, mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b0, 13'h010, 8'h05}) begin
      n_fail++;
      $display("FAIL dma_write: got ack=%b wr=%b rd=%b addr=%h wdata=%h, want 1 1 0 010 05",
               dma_ack, mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    step();
    dma_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dma_ack, mem_rd, mem_wr} !== {1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dma_read_issue: got ack=%b rd=%b wr=%b, want 1 1 0", dma_ack, mem_rd, mem_wr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({dma_rvalid, dma_rdata} !== {1'b1, 8'h05}) begin
      n_fail++;
      $display("FAIL dma_readback: got rv=%b rdata=%h, want 1 05", dma_rvalid, dma_rdata);
    end
    step();
  endtask

  task automatic test_cpu_priority();
    cpu_rd = 1'b1; cpu_addr = 13'h020;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h030;
    @(negedge clk);
    n_checks++;
    if ({mem_rd, mem_addr, dma_ack} !== {1'b1, 13'h020, 1'b0}) begin
      n_fail++;
      $display("FAIL cpu_priority: got rd=%b addr=%h ack=%b, want 1 020 0", mem_rd, mem_addr, dma_ack);
    end
    step();
    cpu_rd = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dma_ack, mem_addr} !== {1'b1, 13'h030}) begin
      n_fail++;
      $display("FAIL dma_idle_slot: got ack=%b addr=%h, want 1 030", dma_ack, mem_addr);
    end
    step();
    idle_inputs();
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 13'h040; cpu_wdata = 8'h77;
    @(negedge clk);
    n_checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 13'h040, 8'h77}) begin
      n_fail++;
      $display("FAIL write_wins: got wr=%b rd=%b addr=%h wdata=%h, want 1 0 040 77",
               mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_starvation();
    int n, acks;
    cpu_rd = 1'b1; cpu_addr = 13'h080;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h100; dma_wdata = 8'h33;
    wait_hold(n, acks);
    n_checks++;
    if (n != SL - 1) begin
      n_fail++;
      $display("FAIL starve_rise: hold rose after %0d cycles, want %0d", n, SL - 1);
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL starve_no_ack: got %0d acks while CPU busy, want 0", acks);
    end
    if (n < 0) begin
      idle_inputs();
      return;
    end
    n_checks++;
    if ({dma_ack, mem_rd, mem_addr} !== {1'b0, 1'b1, 13'h080}) begin
      n_fail++;
      $display("FAIL quiesce: got ack=%b rd=%b addr=%h, want 0 1 080", dma_ack, mem_rd, mem_addr);
    end
    step();
    for (int b = 0; b < MB; b++) begin
      @(negedge clk);
      n_checks++;
      if ({cpu_hold, dma_ack, mem_wr, mem_rd, mem_addr} !== {1'b1, 1'b1, 1'b1, 1'b0, 13'h100}) begin
        n_fail++;
        $display("FAIL hold_beat%0d: got hold=%b ack=%b wr=%b rd=%b addr=%h, want 1 1 1 0 100",
                 b, cpu_hold, dma_ack, mem_wr, mem_rd, mem_addr);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if ({cpu_hold, dma_ack, mem_rd, mem_addr} !== {1'b0, 1'b0, 1'b1, 13'h080}) begin
      n_fail++;
      $display("FAIL hold_exit: got hold=%b ack=%b rd=%b addr=%h, want 0 0 1 080",
               cpu_hold, dma_ack, mem_rd, mem_addr);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_read_top_addr();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h1FFF; dma_wdata = 8'hA5;
    @(negedge clk);
    n_checks++;
    if ({dma_ack, mem_wr, mem_addr} !== {1'b1, 1'b1, 13'h1FFF}) begin
      n_fail++;
      $display("FAIL top_write: got ack=%b wr=%b addr=%h, want 1 1 1fff", dma_ack, mem_wr, mem_addr);
    end
    step();
    dma_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dma_ack, mem_rd, mem_addr} !== {1'b1, 1'b1, 13'h1FFF}) begin
      n_fail++;
      $display("FAIL top_read: got ack=%b rd=%b addr=%h, want 1 1 1fff", dma_ack, mem_rd, mem_addr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({dma_rvalid, dma_rdata} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL top_rdata: got rv=%b rdata=%h, want 1 a5", dma_rvalid, dma_rdata);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_pulse: got rv=%b one cycle later, want 0", dma_rvalid);
    end
    step();
  endtask

  task automatic test_reset_mid_hold();
    int n, acks;
    cpu_rd = 1'b1; cpu_addr = 13'h000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h010;
    wait_hold(n, acks);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL rst_hold_entry: cpu_hold never rose, want rise within 60 cycles");
      idle_inputs();
      return;
    end
    step();
    @(negedge clk);
    n_checks++;
    if (dma_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_beat1: got ack=%b, want 1", dma_ack);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dma_ack, dma_rvalid} !== {1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_beat2: got ack=%b rv=%b, want 1 1", dma_ack, dma_rvalid);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_hold, dma_rvalid, dma_ack, mem_rd} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_hold: got hold=%b rv=%b ack=%b rd=%b, want 0 0 0 1",
               cpu_hold, dma_rvalid, dma_ack, mem_rd);
    end
    step();
    idle_inputs();
    step();
  endtask

`ifdef ARB_ERR_EN
  task automatic test_err_flag();
    int n, acks;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h050; dma_wdata = 8'h11;
    step();
    idle_inputs();
    cpu_rd = 1'b1; cpu_addr = 13'h070;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h060;
    wait_hold(n, acks);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL err_hold_entry: cpu_hold never rose, want rise within 60 cycles");
      idle_inputs();
      return;
    end
    step();
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 13'h050; cpu_wdata = 8'hEE;
    @(negedge clk);
    n_checks++;
    if ({mem_wr, dma_ack} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL err_blocked: got wr=%b ack=%b, want 0 1", mem_wr, dma_ack);
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (err_hold_access !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got err=%b, want 1", err_hold_access);
    end
    step();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h050;
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({dma_rvalid, dma_rdata, err_hold_access} !== {1'b1, 8'h11, 1'b1}) begin
      n_fail++;
      $display("FAIL err_mem_kept: got rv=%b rdata=%h err=%b, want 1 11 1",
               dma_rvalid, dma_rdata, err_hold_access);
    end
    step();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (err_hold_access !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b after rst, want 0", err_hold_access);
    end
    step();
  endtask
`endif

  // Randomized traffic against a model phrased as: normal / quiesce / burst window.
  task automatic test_random();
    int mode, waited, beats;
    logic e_rv, last_ack, e_ack, served;
    logic [DW-1:0] e_rdata;
    logic e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [31:0] r;
    bit heavy;
    do_reset();
    for (int a = 0; a < 16; a++) ref_mem[a] = ram[a];
    mode = 0; waited = 0; beats = 0;
    e_rv = 1'b0; e_rdata = '0; last_ack = 1'b0;
    for (int c = 0; c < 800; c++) begin
      heavy = ((c / 80) % 2) == 0;
      r = $urandom;
      if (r[6:0] < (heavy ? 7'd124 : 7'd45)) begin
        cpu_rd = r[8] | ~r[9];
        cpu_wr = r[9];
      end else begin
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
      end
      cpu_addr = {9'd0, r[13:10]};
      cpu_wdata = r[21:14];
      r = $urandom;
      if (dma_req && last_ack) dma_req = 1'b0;
      if (dma_req && r[5:0] == 6'd0) dma_req = 1'b0;
      if (!dma_req && r[7:6] != 2'd0) begin
        dma_req = 1'b1;
        dma_we = r[8];
        dma_addr = {9'd0, r[12:9]};
        dma_wdata = r[20:13];
      end

      served = 1'b0;
      e_ack = 1'b0;
      if (mode == 0) begin
        served = cpu_rd | cpu_wr;
        e_ack = !(cpu_rd | cpu_wr) && dma_req;
      end else if (mode == 1) begin
        served = cpu_rd | cpu_wr;
      end else begin
        e_ack = dma_req;
      end
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
      if (served) begin
        e_wr = cpu_wr; e_rd = cpu_rd && !cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wdata;
      end else if (e_ack) begin
        e_wr = dma_we; e_rd = !dma_we; e_addr = dma_addr; e_wdata = dma_wdata;
      end

      @(negedge clk);
      n_checks++;
      if ({dma_ack, mem_rd, mem_wr, mem_addr, mem_wdata} !== {e_ack, e_rd, e_wr, e_addr, e_wdata}) begin
        n_fail++;
        $display("FAIL rand_port c=%0d: got ack=%b rd=%b wr=%b addr=%h wdata=%h, want %b %b %b %h %h",
                 c, dma_ack, mem_rd, mem_wr, mem_addr, mem_wdata, e_ack, e_rd, e_wr, e_addr, e_wdata);
      end
      n_checks++;
      if (cpu_hold !== (mode != 0)) begin
        n_fail++;
        $display("FAIL rand_hold c=%0d: got %b, want %b", c, cpu_hold, (mode != 0));
      end
      n_checks++;
      if (dma_rvalid !== e_rv || (e_rv && dma_rdata !== e_rdata)) begin
        n_fail++;
        $display("FAIL rand_rdata c=%0d: got rv=%b rdata=%h, want rv=%b rdata=%h",
                 c, dma_rvalid, dma_rdata, e_rv, e_rdata);
      end

      e_rv = e_ack && !dma_we;
      if (e_rv) e_rdata = ref_mem[dma_addr[3:0]];
      if (e_wr) ref_mem[e_addr[3:0]] = e_wdata;
      if (mode == 0) begin
        if (dma_req && !e_ack) begin
          waited++;
          if (waited == SL - 1) mode = 1;
        end else begin
          waited = 0;
        end
      end else if (mode == 1) begin
        mode = 2;
      end else begin
        if (dma_req) beats++;
        if (!dma_req || beats == MB) begin
          mode = 0; beats = 0; waited = 0;
        end
      end
      last_ack = e_ack;
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_dma_write_read();
    test_cpu_priority();
    test_starvation();
    test_read_top_addr();
    test_reset_mid_hold();
`ifdef ARB_ERR_EN
    test_err_flag();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
